// File: rtl/count_pkg.sv
// Shared definitions for the parametrised synchronous counter family:
// run-control state encoding and the preset clamp helper.
package count_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Limits a preset value to the inclusive upper bound; callers use up to 32-bit widths.
  function automatic logic [31:0] clamp_load(input logic [31:0] value, input logic [31:0] maxv);
    return (value > maxv) ? maxv : value;
  endfunction

endpackage

// File: rtl/count_syn_gen.sv
// Parametrised up/down counter with wrap or saturate bounds, optional one-shot
// run control, registered terminal-count and sticky overflow status.
module count_syn_gen
  import count_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MAX     = 2**WIDTH-1,
  parameter bit WRAP    = 1'b1,
  parameter bit ONESHOT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             preset,
  input  logic             start,
  input  logic             up,
  input  logic [WIDTH-1:0] inp,
  output logic [WIDTH-1:0] outp,
  output logic             tc,
  output logic             ovf,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);

  if (MAX < 1 || longint'(MAX) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
    $error("count_syn_gen: MAX must lie in 1..2**WIDTH-1");
  end

  state_t           state;
  state_t           stateNext;
  logic [WIDTH-1:0] countNext;
  logic [WIDTH-1:0] loadVal;
  logic             countEdge;
  logic             terminal;

  assign loadVal = WIDTH'(clamp_load(32'(inp), 32'(MAX)));
  assign busy    = (state == ST_RUN);

  // A terminal step holds at the bound unless free-running in wrap mode.
  always_comb begin
    countEdge = start && (state != ST_DONE);
    terminal  = up ? (outp == MAXV) : (outp == '0);
    countNext = outp;
    if (countEdge && !terminal) begin
      countNext = up ? outp + WIDTH'(1) : outp - WIDTH'(1);
    end else if (countEdge && !ONESHOT && WRAP) begin
      countNext = up ? '0 : MAXV;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: begin
        if (countEdge) begin
          stateNext = (terminal && ONESHOT) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (!start) begin
          stateNext = ST_IDLE;
        end else if (terminal && ONESHOT) begin
          stateNext = ST_DONE;
        end
      end
      ST_DONE: stateNext = ST_DONE;
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outp  <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
      state <= ST_IDLE;
    end else if (clear) begin
      outp  <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
      state <= ST_IDLE;
    end else if (preset) begin
      outp  <= loadVal;
      tc    <= 1'b0;
      state <= ST_IDLE;
    end else begin
      outp  <= countNext;
      tc    <= countEdge && terminal;
      state <= stateNext;
      if (countEdge && terminal) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule
